// File: rtl/reg_bank_pkg.sv
// Shared operation encodings for the register bank and its ALU.
package reg_bank_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_LOAD  = 2'b00;
  localparam op_t OP_INC   = 2'b01;
  localparam op_t OP_CLEAR = 2'b10;
  localparam op_t OP_ACC   = 2'b11;

endpackage

// File: rtl/reg_alu.sv
// Combinational next-value unit: computes the updated register word and the
// wrap-around carry for the selected operation.
module reg_alu
  import reg_bank_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] cur,
  input  logic [DATA_WIDTH-1:0] operand,
  output logic [DATA_WIDTH-1:0] nxt,
  output logic                  carry
);

  logic [DATA_WIDTH:0] sum;

  always_comb begin
    sum   = '0;
    nxt   = cur;
    carry = 1'b0;
    case (op)
      OP_LOAD:  nxt = operand;
      OP_INC: begin
        sum   = {1'b0, cur} + {{DATA_WIDTH{1'b0}}, 1'b1};
        nxt   = sum[DATA_WIDTH-1:0];
        carry = sum[DATA_WIDTH];
      end
      OP_CLEAR: nxt = '0;
      OP_ACC: begin
        sum   = {1'b0, cur} + {1'b0, operand};
        nxt   = sum[DATA_WIDTH-1:0];
        carry = sum[DATA_WIDTH];
      end
      default:  nxt = cur;
    endcase
  end

endmodule

// File: rtl/reg_bank.sv
// Flop-based register bank with one read-modify-write port, two registered
// read ports with write-through bypass, and a wrap (overflow) pulse.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REGS   = 8,
  parameter int unsigned ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [1:0]            op,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  output logic [DATA_WIDTH-1:0] rd_data_b,
  output logic                  ovf
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_hit;
  logic                  wr_valid;
  logic [DATA_WIDTH-1:0] cur_val;
  logic [DATA_WIDTH-1:0] alu_nxt;
  logic                  alu_carry;
  logic [DATA_WIDTH-1:0] rd_a_d, rd_a_q;
  logic [DATA_WIDTH-1:0] rd_b_d, rd_b_q;
  logic                  ovf_d, ovf_q;

  // Out-of-range write addresses match no entry, so they fall out as no-ops.
  always_comb begin
    wr_hit  = '0;
    cur_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_hit[i] = we && (wr_addr == ADDR_WIDTH'(i));
      if (wr_hit[i]) cur_val = regs_q[i];
    end
  end

  assign wr_valid = |wr_hit;

  reg_alu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .op     (op),
    .cur    (cur_val),
    .operand(data_in),
    .nxt    (alu_nxt),
    .carry  (alu_carry)
  );

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = wr_hit[i] ? alu_nxt : regs_q[i];
    end
  end

  // Reads see the post-operation value when they target the register being written.
  always_comb begin
    rd_a_d = '0;
    rd_b_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr_a == ADDR_WIDTH'(i)) rd_a_d = regs_d[i];
      if (rd_addr_b == ADDR_WIDTH'(i)) rd_b_d = regs_d[i];
    end
  end

  assign ovf_d = wr_valid && alu_carry;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      rd_a_q <= '0;
      rd_b_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
      rd_a_q <= rd_a_d;
      rd_b_q <= rd_b_d;
      ovf_q  <= ovf_d;
    end
  end

  assign rd_data_a = rd_a_q;
  assign rd_data_b = rd_b_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_reg_bank.sv
// Directed bench for reg_bank: an 8-bit/6-register instance and a
// 16-bit/4-register instance, checked against a queue of expected reads.
module tb_reg_bank;
  import reg_bank_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       we8;
  logic [1:0] op8;
  logic [2:0] wa8, ra8, rb8;
  logic [7:0] din8, a8, b8;
  logic       ovf8;

  logic        we16;
  logic [1:0]  op16;
  logic [1:0]  wa16, ra16, rb16;
  logic [15:0] din16, a16, b16;
  logic        ovf16;

  reg_bank #(.DATA_WIDTH(8), .NUM_REGS(6)) dut8 (
    .clk      (clk),
    .rst      (rst),
    .we       (we8),
    .op       (op8),
    .wr_addr  (wa8),
    .data_in  (din8),
    .rd_addr_a(ra8),
    .rd_addr_b(rb8),
    .rd_data_a(a8),
    .rd_data_b(b8),
    .ovf      (ovf8)
  );

  reg_bank #(.DATA_WIDTH(16), .NUM_REGS(4)) dut16 (
    .clk      (clk),
    .rst      (rst),
    .we       (we16),
    .op       (op16),
    .wr_addr  (wa16),
    .data_in  (din16),
    .rd_addr_a(ra16),
    .rd_addr_b(rb16),
    .rd_data_a(a16),
    .rd_data_b(b16),
    .ovf      (ovf16)
  );

  typedef struct {
    string       tag;
    bit          wide;
    logic [15:0] a;
    logic [15:0] b;
    logic        o;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Drive one cycle on the selected instance, queue the expected reads, then
  // sample #1 after the edge and compare against the oldest queued entry.
  task automatic step(input bit wide, input bit r, input bit w, input logic [1:0] o,
                      input int wa, input logic [15:0] d, input int ra, input int rb,
                      input logic [15:0] ea, input logic [15:0] eb, input logic eo,
                      input string tag);
    exp_t e, got;
    logic [15:0] oa, ob;
    logic        oo;
    e.tag = tag; e.wide = wide; e.a = ea; e.b = eb; e.o = eo;
    q.push_back(e);
    rst = r;
    if (wide) begin
      we16 = w; op16 = o; wa16 = 2'(wa); din16 = d; ra16 = 2'(ra); rb16 = 2'(rb);
      we8  = 1'b0;
    end else begin
      we8  = w; op8 = o; wa8 = 3'(wa); din8 = d[7:0]; ra8 = 3'(ra); rb8 = 3'(rb);
      we16 = 1'b0;
    end
    @(posedge clk);
    #1;
    got = q.pop_front();
    oa = got.wide ? a16 : {8'h00, a8};
    ob = got.wide ? b16 : {8'h00, b8};
    oo = got.wide ? ovf16 : ovf8;
    checks++;
    assert (oa === got.a) else begin
      errors++;
      $error("FAIL %s rd_data_a got %h expected %h", got.tag, oa, got.a);
    end
    checks++;
    assert (ob === got.b) else begin
      errors++;
      $error("FAIL %s rd_data_b got %h expected %h", got.tag, ob, got.b);
    end
    checks++;
    assert (oo === got.o) else begin
      errors++;
      $error("FAIL %s ovf got %b expected %b", got.tag, oo, got.o);
    end
  endtask

  initial begin
    rst = 1'b1;
    we8 = 1'b0; op8 = OP_LOAD; wa8 = '0; din8 = '0; ra8 = '0; rb8 = '0;
    we16 = 1'b0; op16 = OP_LOAD; wa16 = '0; din16 = '0; ra16 = '0; rb16 = '0;

    // Reset, then every address (including out-of-range 6 and 7) reads 0.
    step(0, 1, 0, OP_LOAD, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0, "reset0");
    step(0, 1, 0, OP_LOAD, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0, "reset1");
    for (int i = 0; i < 8; i++)
      step(0, 0, 0, OP_LOAD, 0, 16'h0, i, 7 - i, 16'h0, 16'h0, 0, "read_zero");

    // LOAD / ACC with wrap on reg3; ovf is a single-cycle pulse.
    step(0, 0, 1, OP_LOAD, 3, 16'h7F, 3, 3, 16'h7F, 16'h7F, 0, "load_r3");
    step(0, 0, 1, OP_ACC,  3, 16'h01, 3, 0, 16'h80, 16'h00, 0, "acc_r3_01");
    step(0, 0, 1, OP_ACC,  3, 16'h80, 3, 3, 16'h00, 16'h00, 1, "acc_r3_wrap");
    step(0, 0, 0, OP_LOAD, 0, 16'h00, 3, 5, 16'h00, 16'h00, 0, "ovf_one_cycle");

    // INC wrap on reg5 with same-cycle bypass read.
    step(0, 0, 1, OP_LOAD, 5, 16'hFF, 5, 3, 16'hFF, 16'h00, 0, "load_r5");
    step(0, 0, 1, OP_INC,  5, 16'h00, 5, 5, 16'h00, 16'h00, 1, "inc_r5_wrap");
    step(0, 0, 0, OP_INC,  5, 16'h00, 5, 5, 16'h00, 16'h00, 0, "we0_no_inc");

    // Out-of-range writes are ignored; out-of-range reads give 0.
    step(0, 0, 1, OP_LOAD, 0, 16'h55, 1, 0, 16'h00, 16'h55, 0, "load_r0");
    step(0, 0, 1, OP_LOAD, 7, 16'hAA, 0, 7, 16'h55, 16'h00, 0, "load_addr7");
    step(0, 0, 1, OP_INC,  6, 16'h00, 0, 6, 16'h55, 16'h00, 0, "inc_addr6");
    step(0, 0, 0, OP_LOAD, 0, 16'h00, 7, 0, 16'h00, 16'h55, 0, "after_oob");

    // Reset dominates a concurrent LOAD; then CLEAR after LOAD.
    step(0, 1, 1, OP_LOAD, 1, 16'h12, 1, 0, 16'h00, 16'h00, 0, "rst_vs_load");
    step(0, 0, 0, OP_LOAD, 0, 16'h00, 1, 0, 16'h00, 16'h00, 0, "after_rst");
    step(0, 0, 1, OP_LOAD, 2, 16'h34, 2, 1, 16'h34, 16'h00, 0, "load_r2");
    step(0, 0, 1, OP_CLEAR, 2, 16'hFF, 2, 2, 16'h00, 16'h00, 0, "clear_r2");
    step(0, 0, 0, OP_LOAD, 0, 16'h00, 2, 2, 16'h00, 16'h00, 0, "read_r2");

    // Plain ACC wrap without bypass on the read ports.
    step(0, 0, 1, OP_LOAD, 1, 16'hAB, 0, 1, 16'h00, 16'hAB, 0, "load_r1");
    step(0, 0, 1, OP_ACC,  1, 16'h60, 4, 2, 16'h00, 16'h00, 1, "acc_r1_wrap");
    step(0, 0, 0, OP_LOAD, 0, 16'h00, 1, 1, 16'h0B, 16'h0B, 0, "read_r1");

    // 16-bit / 4-register instance.
    step(1, 1, 0, OP_LOAD, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0, "w_reset0");
    step(1, 1, 0, OP_LOAD, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0, "w_reset1");
    step(1, 0, 1, OP_ACC, 0, 16'hFFFF, 0, 3, 16'hFFFF, 16'h0000, 0, "w_acc1");
    step(1, 0, 1, OP_ACC, 0, 16'hFFFF, 0, 0, 16'hFFFE, 16'hFFFE, 1, "w_acc2");
    step(1, 0, 0, OP_ACC, 0, 16'hFFFF, 3, 0, 16'h0000, 16'hFFFE, 0, "w_hold");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of every stored word.
REQ-002 Parameter NUM_REGS, default 8: number of registers, >=2, need not be a power of two.
REQ-003 Parameter ADDR_WIDTH, default $clog2(NUM_REGS): address width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 we  in  1  write/operation enable for wr_addr this cycle.
REQ-007 op  in  2  operation: 00 LOAD, 01 INC, 10 CLEAR, 11 ACC (add).
REQ-008 wr_addr  in  ADDR_WIDTH  target register of op.
REQ-009 data_in  in  DATA_WIDTH  operand for LOAD/ACC.
REQ-010 rd_addr_a  in  ADDR_WIDTH  read port A address.
REQ-011 rd_addr_b  in  ADDR_WIDTH  read port B address.
REQ-012 rd_data_a  out  DATA_WIDTH  registered read data, port A.
REQ-013 rd_data_b  out  DATA_WIDTH  registered read data, port B.
REQ-014 ovf  out  1  one-cycle pulse: INC or ACC wrapped this cycle.

Function
REQ-015 With we=1 the bank SHALL update reg[wr_addr] at the clock edge: LOAD->data_in, INC->reg+1, CLEAR->0, ACC->reg+data_in.
REQ-016 INC and ACC SHALL be modulo 2^DATA_WIDTH; carry out SHALL drive ovf=1 in the cycle after the edge, else ovf=0.
REQ-017 LOAD and CLEAR SHALL always give ovf=0; we=0 SHALL give ovf=0 and leave all registers unchanged.
REQ-018 Read ports SHALL have 1-cycle latency: rd_data_x at edge N+1 reflects rd_addr_x sampled at edge N.
REQ-019 Same-cycle read of wr_addr with we=1 SHALL return the post-operation value (write-through bypass), on both ports independently.
REQ-020 Both read ports SHALL read the same address concurrently without conflict.
REQ-021 wr_addr >= NUM_REGS SHALL be ignored (no state change, ovf=0).
REQ-022 rd_addr_x >= NUM_REGS SHALL return 0 on that port.
REQ-023 Only one register SHALL change per cycle; all others hold.

Reset
REQ-024 rst=1 at an edge SHALL clear all registers, rd_data_a, rd_data_b and ovf to 0.
REQ-025 rst SHALL dominate we: an operation presented with rst=1 SHALL have no effect.
REQ-026 The first edge after rst deasserts SHALL perform normal operation and reads.

Structure
REQ-027 Package reg_bank_pkg SHALL hold op encodings OP_LOAD, OP_INC, OP_CLEAR, OP_ACC as 2-bit constants.
REQ-028 Sub-module reg_alu (combinational) SHALL compute next value and carry from op, current value, data_in; the bank instantiates it once.
REQ-029 Storage SHALL be a flop array, not inferred block RAM, to support bypass and full reset.

Verification
REQ-030 rst 2 cycles -> rd_data_a=rd_data_b=0, ovf=0; read all addresses -> all 0.
REQ-031 LOAD reg3=8'h7F, then ACC reg3 with 8'h01 -> reg3=8'h80, ovf=0; ACC 8'h80 -> reg3=8'h00, ovf=1 for exactly one cycle.
REQ-032 LOAD reg5=8'hFF, INC reg5 with rd_addr_a=5 same cycle -> rd_data_a=8'h00 next cycle, ovf=1.
REQ-033 NUM_REGS=6: LOAD wr_addr=7 data 8'hAA -> no register changes; rd_addr_b=7 -> 8'h00.
REQ-034 LOAD reg1=8'h12 with rst=1 same edge -> reg1=0; CLEAR reg2 after LOAD 8'h34 -> reads 0, ovf=0.
REQ-035 DATA_WIDTH=16, NUM_REGS=4: ACC reg0 with 16'hFFFF twice from 0 -> 16'hFFFF then 16'hFFFE, ovf 0 then 1.
